// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: FSM states, opcode/funct
// codes and the ALU operation encoding.
package mips_mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        alu_op_t op;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear, register 0 hardwired to zero.
module mips_mc_regfile
    import mips_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int RIDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RIDX_W-1:0] raddr1,
    input  logic [RIDX_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_live
                logic [DATA_W-1:0] q_reg;
                always_ff @(posedge clk) begin
                    if (!reset) begin
                        q_reg <= '0;
                    end else if (we && (waddr == RIDX_W'(gi))) begin
                        q_reg <= wdata;
                    end
                end
                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 subset core with one shared req/ready memory port.
// Define MIPS_MC_PERF_EN to add the cycle_cnt / retired_cnt counters.
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter int          NREGS    = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
`ifdef MIPS_MC_PERF_EN
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retired_cnt
`else
    output logic [ADDR_W-1:0] pc_dbg
`endif
);

    localparam int RIDX_W = $clog2(NREGS);
    localparam int EXT_W  = (ADDR_W > 32) ? ADDR_W : 32;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [31:0]       ir_reg, ir_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [DATA_W-1:0] alu_out_reg, alu_out_next;
    logic [DATA_W-1:0] mdr_reg, mdr_next;

    // Instruction fields and decode
    logic [5:0]        opcode, funct;
    logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx;
    logic              is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_halt;
    logic [DATA_W-1:0] imm_data;
    logic [EXT_W-1:0]  imm_addr;
    logic [ADDR_W-1:0] branch_target, jump_target;

    assign opcode   = ir_reg[31:26];
    assign funct    = ir_reg[5:0];
    assign rs_idx   = ir_reg[21 +: RIDX_W];
    assign rt_idx   = ir_reg[16 +: RIDX_W];
    assign rd_idx   = ir_reg[11 +: RIDX_W];
    assign is_rtype = (opcode == OP_RTYPE) && funct_legal(funct);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_halt  = (opcode == OP_HALT);

    assign imm_data      = {{(DATA_W-16){ir_reg[15]}}, ir_reg[15:0]};
    assign imm_addr      = {{(EXT_W-16){ir_reg[15]}}, ir_reg[15:0]};
    assign branch_target = pc_reg + imm_addr[ADDR_W-1:0];

    always_comb begin
        jump_target       = pc_reg;
        jump_target[25:0] = ir_reg[25:0];
    end

    // Shamt bits, index bits above RIDX_W and wide immediate bits are don't-cares
    logic sig_unused;
    assign sig_unused = ^{ir_reg, imm_addr};

    // Register file
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic              rf_we;
    logic [RIDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign rf_we    = (state_reg == ST_WB);
    assign rf_waddr = is_rtype ? rd_idx : rt_idx;
    assign rf_wdata = is_lw ? mdr_reg : alu_out_reg;

    mips_mc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs_idx),
        .raddr2 (rt_idx),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // ALU
    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b, alu_result;

    assign alu_op = is_rtype ? funct_to_alu(funct) : ALU_ADD;
    assign alu_b  = is_rtype ? b_reg : imm_data;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = a_reg + alu_b;
            ALU_SUB: alu_result = a_reg - alu_b;
            ALU_AND: alu_result = a_reg & alu_b;
            ALU_OR:  alu_result = a_reg | alu_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(a_reg) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    // Next-state logic. j and illegal words pass through an idle EXEC so both
    // take three states; j still updates PC in DECODE.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        alu_out_next = alu_out_reg;
        mdr_next     = mdr_reg;
        case (state_reg)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_next    = mem_rdata[31:0];
                    pc_next    = pc_reg + ADDR_W'(1);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_next = rf_rdata1;
                b_next = rf_rdata2;
                if (is_halt) begin
                    state_next = ST_HALTED;
                end else begin
                    state_next = ST_EXEC;
                    if (is_j) begin
                        pc_next = jump_target;
                    end
                end
            end
            ST_EXEC: begin
                if (is_rtype || is_addi) begin
                    alu_out_next = alu_result;
                    state_next   = ST_WB;
                end else if (is_lw || is_sw) begin
                    alu_out_next = alu_result;
                    state_next   = ST_MEM;
                end else begin
                    if (is_beq && (a_reg == b_reg)) begin
                        pc_next = branch_target;
                    end
                    state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (is_lw) begin
                        mdr_next   = mem_rdata;
                        state_next = ST_WB;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_WB:     state_next = ST_FETCH;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_FETCH;
            pc_reg      <= ADDR_W'(RESET_PC);
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            alu_out_reg <= alu_out_next;
            mdr_reg     <= mdr_next;
        end
    end

    // Memory port is decoded from state; gating with reset forces it idle
    // during reset, and the FETCH request appears as soon as reset releases.
    logic in_fetch, in_mem;
    assign in_fetch = (state_reg == ST_FETCH);
    assign in_mem   = (state_reg == ST_MEM);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (in_fetch) begin
                mem_req  = 1'b1;
                mem_addr = pc_reg;
            end else if (in_mem) begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                mem_addr  = ADDR_W'(alu_out_reg);
                mem_wdata = b_reg;
            end
        end
    end

    assign halted = reset && (state_reg == ST_HALTED);
    assign pc_dbg = pc_reg;

`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt_reg, retired_cnt_reg;
    logic        retire;

    assign retire = (state_next == ST_FETCH) &&
                    (state_reg inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB});

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt_reg   <= '0;
            retired_cnt_reg <= '0;
        end else begin
            if (state_reg != ST_HALTED) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            end
            if (retire) begin
                retired_cnt_reg <= retired_cnt_reg + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign retired_cnt = retired_cnt_reg;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed programs against the multi-cycle core; memory writes are checked
// against a queue of expected stores, plus cycle counts and port behaviour.
module tb_mips_multicycle_core;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

    logic        mem_req64, mem_we64, mem_ready64, halted64;
    logic [31:0] mem_addr64, pc_dbg64;
    logic [63:0] mem_wdata64, mem_rdata64;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [31:0] mem   [256];
    logic [63:0] mem64 [64];
    int          wait_cfg  = 0;
    logic        hold_data = 1'b0;

`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt, cycle_cnt64, retired_cnt64;
`endif

    mips_multicycle_core #(.DATA_W(32), .ADDR_W(32), .NREGS(32), .RESET_PC(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .halted      (halted),
`ifdef MIPS_MC_PERF_EN
        .pc_dbg      (pc_dbg),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`else
        .pc_dbg      (pc_dbg)
`endif
    );

    mips_multicycle_core #(.DATA_W(64), .ADDR_W(32), .NREGS(16), .RESET_PC(0)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req64),
        .mem_we      (mem_we64),
        .mem_addr    (mem_addr64),
        .mem_wdata   (mem_wdata64),
        .mem_rdata   (mem_rdata64),
        .mem_ready   (mem_ready64),
        .halted      (halted64),
`ifdef MIPS_MC_PERF_EN
        .pc_dbg      (pc_dbg64),
        .cycle_cnt   (cycle_cnt64),
        .retired_cnt (retired_cnt64)
`else
        .pc_dbg      (pc_dbg64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int target);
        return {6'b000010, 26'(target)};
    endfunction

    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    // 32-bit memory model: wait states, address/we stability, store scoreboard
    initial begin
        logic        pend;
        logic        stall;
        logic [31:0] held_addr;
        logic        held_we;
        int          wait_cnt;
        pend = 1'b0; wait_cnt = 0; held_addr = '0; held_we = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && mem_req === 1'b1) begin
                if (pend) begin
                    check("addr_stable", mem_addr, held_addr);
                    check("we_stable", mem_we, held_we);
                end
                stall = (hold_data && mem_we) || (wait_cnt < wait_cfg);
                if (stall) begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                    if (!pend) begin
                        held_addr = mem_addr;
                        held_we   = mem_we;
                    end
                    pend = 1'b1;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[7:0]];
                    wait_cnt  = 0;
                    pend      = 1'b0;
                    if (mem_we) begin
                        $display("store addr=%h data=%h", mem_addr, mem_wdata);
                        mem[mem_addr[7:0]] = mem_wdata;
                        checks++;
                        assert (exp_q.size() != 0) else begin
                            errors++;
                            $error("FAIL unexpected_store: observed addr=%h data=%h expected none", mem_addr, mem_wdata);
                        end
                        if (exp_q.size() != 0) begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("store_addr", mem_addr, e.addr);
                            check("store_data", mem_wdata, e.data);
                        end
                    end
                end
            end else begin
                mem_ready = 1'b0;
                pend      = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // 64-bit memory model: zero wait states
    initial begin
        mem_ready64 = 1'b0;
        mem_rdata64 = '0;
        forever begin
            @(negedge clk);
            mem_ready64 = (reset === 1'b1) && (mem_req64 === 1'b1);
            if (mem_ready64) begin
                mem_rdata64 = mem64[mem_addr64[5:0]];
                if (mem_we64) mem64[mem_addr64[5:0]] = mem_wdata64;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_rst_req"}, mem_req, 1'b0);
        check({tag, "_rst_halted"}, halted, 1'b0);
        check({tag, "_rst_pc"}, pc_dbg, 32'h0);
        reset = 1'b1;
        #1;
        check({tag, "_first_req"}, mem_req, 1'b1);
        check({tag, "_first_addr"}, mem_addr, 32'h0);
    endtask

    task automatic run_to_halt(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 64; i++) mem64[i] = 64'h0;
        mem64[0] = {32'hA5A5_A5A5, enc_i(ADDI, 0, 17, -1)};
        mem64[1] = {32'h5A5A_5A5A, enc_i(SW, 0, 1, 16)};
        mem64[2] = {32'h0, HALT_W};

        // Arithmetic, write-back and store
        clear_mem();
        mem[0] = enc_i(ADDI, 0, 1, 5);
        mem[1] = enc_i(ADDI, 0, 2, -3);
        mem[2] = enc_r(1, 2, 3, F_ADD);
        mem[3] = enc_i(SW, 0, 3, 16);
        mem[4] = HALT_W;
        expect_store(32'd16, 32'd2);
        do_reset("arith");
        run_to_halt("arith", 18);
        check("arith_pc", pc_dbg, 32'd5);
        check("arith_req_halted", mem_req, 1'b0);
`ifdef MIPS_MC_PERF_EN
        check("arith_cycle_cnt", cycle_cnt, 32'd18);
        check("arith_retired_cnt", retired_cnt, 32'd4);
`endif
        check("w64_halted", halted64, 1'b1);
        check("w64_store", mem64[16], 64'hFFFF_FFFF_FFFF_FFFF);

        // Branches, jump, slt, illegal opcode, r0 writes
        clear_mem();
        mem[0]     = enc_i(ADDI, 0, 1, 5);
        mem[1]     = enc_i(ADDI, 0, 2, -3);
        mem[2]     = enc_r(2, 1, 4, F_SLT);
        mem[3]     = enc_i(SW, 0, 4, 'h40);
        mem[4]     = enc_i(BEQ, 0, 0, 2);
        mem[5]     = enc_i(SW, 0, 1, 'h50);
        mem[6]     = enc_i(SW, 0, 1, 'h51);
        mem[7]     = enc_j('h20);
        mem[8]     = enc_i(SW, 0, 1, 'h52);
        mem['h20]  = enc_i(SW, 0, 2, 'h41);
        mem['h21]  = 32'hF800_0000;
        mem['h22]  = enc_i(BEQ, 1, 2, 4);
        mem['h23]  = enc_r(1, 1, 0, F_ADD);
        mem['h24]  = enc_i(SW, 0, 0, 'h42);
        mem['h25]  = HALT_W;
        expect_store(32'h40, 32'd1);
        expect_store(32'h41, 32'hFFFF_FFFD);
        expect_store(32'h42, 32'd0);
        do_reset("branch");
        run_to_halt("branch", 42);
        check("branch_pc", pc_dbg, 32'h26);

        // Remaining ALU ops and an illegal funct
        clear_mem();
        mem[0]  = enc_i(ADDI, 0, 1, 5);
        mem[1]  = enc_i(ADDI, 0, 2, -3);
        mem[2]  = enc_r(1, 2, 6, F_SUB);
        mem[3]  = enc_r(1, 2, 7, F_AND);
        mem[4]  = enc_r(1, 2, 8, F_OR);
        mem[5]  = enc_r(1, 2, 9, F_SLT);
        mem[6]  = enc_r(1, 2, 1, 6'b100001);
        mem[7]  = enc_i(SW, 0, 6, 'h60);
        mem[8]  = enc_i(SW, 0, 7, 'h61);
        mem[9]  = enc_i(SW, 0, 8, 'h62);
        mem[10] = enc_i(SW, 0, 9, 'h63);
        mem[11] = enc_i(SW, 0, 1, 'h64);
        mem[12] = HALT_W;
        expect_store(32'h60, 32'd8);
        expect_store(32'h61, 32'd5);
        expect_store(32'h62, 32'hFFFF_FFFD);
        expect_store(32'h63, 32'd0);
        expect_store(32'h64, 32'd5);
        do_reset("alu");
        run_to_halt("alu", 49);
        check("alu_pc", pc_dbg, 32'd13);

        // Three wait states on every access
        clear_mem();
        mem[0] = enc_i(LW, 0, 5, 8);
        mem[1] = enc_i(SW, 0, 5, 9);
        mem[2] = HALT_W;
        mem[8] = 32'hDEAD_BEEF;
        expect_store(32'd9, 32'hDEAD_BEEF);
        wait_cfg = 3;
        do_reset("wait");
        run_to_halt("wait", 26);
        wait_cfg = 0;

        // Reset while a store is stalled in MEM
        clear_mem();
        mem[0] = enc_i(ADDI, 0, 1, 7);
        mem[1] = enc_i(SW, 0, 1, 'h70);
        mem[2] = HALT_W;
        expect_store(32'h70, 32'd7);
        do_reset("midrst");
        begin
            int n;
            n = 0;
            while (mem_we !== 1'b1 && n < 100) begin
                @(posedge clk);
                #1 n++;
            end
        end
        check("midrst_in_mem", mem_we, 1'b1);
        hold_data = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_hold_addr", mem_addr, 32'h70);
        check("midrst_hold_data", mem_wdata, 32'd7);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_we", mem_we, 1'b0);
        check("midrst_pc", pc_dbg, 32'h0);
        hold_data = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_refetch_req", mem_req, 1'b1);
        check("midrst_refetch_addr", mem_addr, 32'h0);
        run_to_halt("midrst", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
